add_pipe: RTL

ADD_PIPE -- requirements
Module: add_pipe

---
 rtl/add_pkg.sv | 13 +
 rtl/add_stage.sv | 28 ++
 rtl/add_pipe.sv | 96 +++++++++
 3 files changed

// File: rtl/add_pkg.sv
// rtl/add_pkg.sv - shared mode encodings and default width for the add_pipe block
package add_pkg;

    localparam int ADD_W_DEFAULT = 14;

    typedef enum logic [1:0] {
        MODE_ADD = 2'b00,
        MODE_SUB = 2'b01,
        MODE_ACC = 2'b10,
        MODE_CLR = 2'b11
    } mode_t;

endpackage

// File: rtl/add_stage.sv
// rtl/add_stage.sv - one valid+data+ovf pipeline register with a shared advance enable
module add_stage #(
    parameter int W = 14
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         adv,
    input  logic         d_valid,
    input  logic [W-1:0] d_data,
    input  logic         d_ovf,
    output logic         q_valid,
    output logic [W-1:0] q_data,
    output logic         q_ovf
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_valid <= 1'b0;
            q_data  <= '0;
            q_ovf   <= 1'b0;
        end else if (adv) begin
            q_valid <= d_valid;
            q_data  <= d_data;
            q_ovf   <= d_ovf;
        end
    end

endmodule

// File: rtl/add_pipe.sv
// rtl/add_pipe.sv - pipelined signed add/sub/accumulate with overflow flag
// ADD_PIPE_SAT_EN defined: out-of-range results clamp; undefined: they wrap.
module add_pipe
    import add_pkg::*;
#(
    parameter int W      = ADD_W_DEFAULT,
    parameter int STAGES = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [1:0]   mode,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] sum,
    output logic         ovf
);

    logic         advance;
    logic         accept;
    logic [W-1:0] acc;
    logic [W:0]   a_x;
    logic [W:0]   b_x;
    logic [W:0]   acc_x;
    logic [W:0]   res;
    logic         ovf_c;
    logic [W-1:0] res_w;

    logic [STAGES:0] v;
    logic [STAGES:0] o;
    logic [W-1:0]    d [0:STAGES];

    assign advance  = out_ready | ~out_valid;
    assign in_ready = advance;
    assign accept   = in_valid & advance;

    // One guard bit is enough to hold any sum/difference of two W-bit values.
    always_comb begin
        a_x   = {a[W-1], a};
        b_x   = {b[W-1], b};
        acc_x = {acc[W-1], acc};
        res   = a_x;
        case (mode_t'(mode))
            MODE_ADD: res = a_x + b_x;
            MODE_SUB: res = a_x - b_x;
            MODE_ACC: res = acc_x + a_x;
            default:  res = a_x;
        endcase
    end

    assign ovf_c = res[W] ^ res[W-1];

    always_comb begin
        res_w = res[W-1:0];
`ifdef ADD_PIPE_SAT_EN
        if (ovf_c) begin
            res_w = res[W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
        end
`endif
    end

    // acc is written on the accept edge, so the next beat already sees it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc <= '0;
        end else if (accept && (mode_t'(mode) == MODE_ACC || mode_t'(mode) == MODE_CLR)) begin
            acc <= res_w;
        end
    end

    assign v[0] = in_valid;
    assign o[0] = ovf_c;
    assign d[0] = res_w;

    for (genvar g = 0; g < STAGES; g++) begin : g_stage
        add_stage #(.W(W)) u_stage (
            .clk     (clk),
            .rst     (rst),
            .adv     (advance),
            .d_valid (v[g]),
            .d_data  (d[g]),
            .d_ovf   (o[g]),
            .q_valid (v[g+1]),
            .q_data  (d[g+1]),
            .q_ovf   (o[g+1])
        );
    end

    assign out_valid = v[STAGES];
    assign sum       = d[STAGES];
    assign ovf       = o[STAGES];

endmodule
